count_sequencer: RTL and testbench

//  Clock-enable based run/pause/direction controller for the 4-bit LED up/down counter.

---
 rtl/count_seq_pkg.sv | 20 ++
 rtl/count_sequencer_edge_pulse.sv | 25 ++
 rtl/count_sequencer.sv | 164 ++++++++++++++++
 tb/tb_count_sequencer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/count_seq_pkg.sv
// Shared types and helpers for the count sequencer: FSM state encoding and
// prescaler divide-ratio calculation.
package count_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    HOLD  = 2'd2,
    PAUSE = 2'd3
  } state_e;

  // Clock cycles per tick; never below 1 so a tick can always be produced.
  function automatic int unsigned calc_div(input int unsigned clk_hz,
                                           input int unsigned rate_hz);
    int unsigned div;
    div = (rate_hz == 0) ? 1 : clk_hz / rate_hz;
    return (div < 1) ? 1 : div;
  endfunction

endpackage

// File: rtl/count_sequencer_edge_pulse.sv
// Two-flop synchronizer followed by a rising-edge detector; emits a one-cycle
// pulse for each press of a debounced level input.
module edge_pulse (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_pulse
);

  logic [1:0] r_sync;
  logic       r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_btn};
      r_prev <= r_sync[1];
    end
  end

  assign o_pulse = r_sync[1] & ~r_prev;

endmodule

// File: rtl/count_sequencer.sv
// Run/pause/direction sequencer for the LED up/down counter, clock-enabled by a
// prescaler tick. Optional dwell-and-reverse at limits: COUNT_SEQ_AUTO_REVERSE_EN.
module count_sequencer #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned FAST_HZ    = 10,
  parameter int unsigned SLOW_HZ    = 1,
  parameter int unsigned HOLD_TICKS = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_run,
  input  logic             btn_dir,
  input  logic             speed_sel,
  input  logic [WIDTH-1:0] lo_lim,
  input  logic [WIDTH-1:0] hi_lim,
  output logic [WIDTH-1:0] count,
  output logic             running,
  output logic             dir_up,
  output logic             at_limit,
  output logic             cfg_err,
  output logic             tick
);

  import count_seq_pkg::*;

  localparam int unsigned DIV_FAST = calc_div(CLK_HZ, FAST_HZ);
  localparam int unsigned DIV_SLOW = calc_div(CLK_HZ, SLOW_HZ);
  localparam int unsigned DIV_MAX  = (DIV_FAST > DIV_SLOW) ? DIV_FAST : DIV_SLOW;
  localparam int unsigned PW       = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;

  if (HOLD_TICKS < 1) begin : g_hold_ticks_invalid
  end

  logic             w_run_pulse;
  logic             w_dir_pulse;
  logic             w_cfg_err;
  logic             w_in_range;
  logic             w_at_limit;
  logic             w_step;
  logic             w_hold_done;
  logic             w_running;
  logic [PW-1:0]    w_div_last;
  logic [PW-1:0]    r_presc;
  logic             r_tick;
  logic             r_speed_q;
  logic [WIDTH-1:0] r_count;
  logic             r_dir_up;
  state_e           r_state;
  state_e           w_state_nxt;

  edge_pulse u_run_edge (.clk(clk), .rst_n(rst), .i_btn(btn_run), .o_pulse(w_run_pulse));
  edge_pulse u_dir_edge (.clk(clk), .rst_n(rst), .i_btn(btn_dir), .o_pulse(w_dir_pulse));

  assign w_cfg_err  = (lo_lim > hi_lim);
  assign w_in_range = (r_count >= lo_lim) && (r_count <= hi_lim);
  assign w_at_limit = r_dir_up ? (r_count == hi_lim) : (r_count == lo_lim);
  // A run press outranks a coincident tick: that tick is dropped.
  assign w_step     = (r_state == RUN) && r_tick && !w_run_pulse && !w_cfg_err;
  assign w_div_last = speed_sel ? PW'(DIV_FAST - 1) : PW'(DIV_SLOW - 1);

  // Prescaler restarts from zero whenever the speed selection changes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_presc   <= '0;
      r_tick    <= 1'b0;
      r_speed_q <= 1'b0;
    end else begin
      // NOTE: non-blocking (<=) in clocked blocks so every flop samples pre-edge values.
      r_speed_q <= speed_sel;
      if (speed_sel != r_speed_q) begin
        r_presc <= '0;
        r_tick  <= 1'b0;
      end else if (r_presc == w_div_last) begin
        r_presc <= '0;
        r_tick  <= 1'b1;
      end else begin
        r_presc <= r_presc + PW'(1);
        r_tick  <= 1'b0;
      end
    end
  end

`ifdef COUNT_SEQ_AUTO_REVERSE_EN
  localparam int unsigned HC_W = $clog2(HOLD_TICKS + 1);
  logic [HC_W-1:0] r_hold_cnt;

  assign w_hold_done = (r_state == HOLD) && r_tick && !w_run_pulse && !w_cfg_err &&
                       (r_hold_cnt == HC_W'(HOLD_TICKS - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hold_cnt <= '0;
    end else if ((r_state != HOLD) || w_hold_done) begin
      r_hold_cnt <= '0;
    end else if (r_tick) begin
      r_hold_cnt <= r_hold_cnt + HC_W'(1);
    end
  end
`else
  assign w_hold_done = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    // NOTE: default assignment first so no path leaves w_state_nxt unassigned (no latch).
    w_state_nxt = r_state;
    if (w_cfg_err) begin
      w_state_nxt = PAUSE;
    end else if (w_run_pulse) begin
      case (r_state)
        IDLE:    w_state_nxt = RUN;
        RUN:     w_state_nxt = PAUSE;
        HOLD:    w_state_nxt = PAUSE;
        PAUSE:   w_state_nxt = RUN;
        default: w_state_nxt = IDLE;
      endcase
    end else if (w_step && w_in_range && w_at_limit) begin
`ifdef COUNT_SEQ_AUTO_REVERSE_EN
      w_state_nxt = HOLD;
`else
      w_state_nxt = IDLE;
`endif
    end else if (w_hold_done) begin
      w_state_nxt = RUN;
    end
  end

  always_comb begin
    w_running = (r_state == RUN) || (r_state == HOLD);
  end

  // Out-of-range counts snap to the limit behind the direction of travel.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count  <= '0;
      r_dir_up <= 1'b1;
    end else begin
      r_dir_up <= r_dir_up ^ w_dir_pulse ^ w_hold_done;
      if (w_step) begin
        if (!w_in_range) begin
          r_count <= r_dir_up ? lo_lim : hi_lim;
        end else if (!w_at_limit) begin
          r_count <= r_dir_up ? r_count + WIDTH'(1) : r_count - WIDTH'(1);
        end
      end
    end
  end

  assign count    = r_count;
  assign running  = w_running;
  assign dir_up   = r_dir_up;
  assign at_limit = w_at_limit;
  assign cfg_err  = w_cfg_err;
  assign tick     = r_tick;

endmodule

// File: tb/tb_count_sequencer.sv
// Directed self-checking bench for count_sequencer (DIV 2 fast, DIV 10 slow,
// two dwell ticks); covers both builds of COUNT_SEQ_AUTO_REVERSE_EN.
module tb_count_sequencer;

  localparam int W = 4;

  logic         clk       = 1'b0;
  logic         rst       = 1'b0;
  logic         btn_run   = 1'b0;
  logic         btn_dir   = 1'b0;
  logic         speed_sel = 1'b1;
  logic [W-1:0] lo_lim    = 4'd2;
  logic [W-1:0] hi_lim    = 4'd6;
  logic [W-1:0] count;
  logic         running;
  logic         dir_up;
  logic         at_limit;
  logic         cfg_err;
  logic         tick;

  int n_checks = 0;
  int n_errors = 0;

  count_sequencer #(
    .WIDTH(W), .CLK_HZ(20), .FAST_HZ(10), .SLOW_HZ(2), .HOLD_TICKS(2)
  ) dut (
    .clk(clk), .rst(rst), .btn_run(btn_run), .btn_dir(btn_dir),
    .speed_sel(speed_sel), .lo_lim(lo_lim), .hi_lim(hi_lim),
    .count(count), .running(running), .dir_up(dir_up),
    .at_limit(at_limit), .cfg_err(cfg_err), .tick(tick)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Returns at a falling edge where tick is high (bounded).
  task automatic tick_wait(input string tag, output int n);
    n = 0;
    while (tick !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_tick_seen"}, 32'(tick), 1);
  endtask

  // Waits for a tick, lets the count update on the next edge, then checks it.
  task automatic step(input string tag, input int exp);
    int n;
    tick_wait(tag, n);
    @(negedge clk);
    check(tag, 32'(count), exp);
  endtask

  task automatic press_run();
    btn_run = 1'b1;
    repeat (3) @(negedge clk);
    btn_run = 1'b0;
  endtask

  task automatic press_dir();
    btn_dir = 1'b1;
    repeat (3) @(negedge clk);
    btn_dir = 1'b0;
  endtask

  initial begin
    int n;

    // Reset values while reset is held.
    repeat (2) @(negedge clk);
    check("rst_count",    32'(count),    0);
    check("rst_dir_up",   32'(dir_up),   1);
    check("rst_running",  32'(running),  0);
    check("rst_tick",     32'(tick),     0);
    check("rst_at_limit", 32'(at_limit), 0);
    check("rst_cfg_err",  32'(cfg_err),  0);
    rst = 1'b1;
    @(negedge clk);

    // lo=2, hi=6, up, fast: load lo then step to hi.
    press_run();
    check("b_running", 32'(running), 1);
    step("b_c2", 2);
    step("b_c3", 3);
    tick_wait("b_period", n);
    check("b_fast_period", n, 1);
    @(negedge clk);
    check("b_c4", 32'(count), 4);
    step("b_c5", 5);
    step("b_c6", 6);
    check("b_at_limit", 32'(at_limit), 1);
`ifdef COUNT_SEQ_AUTO_REVERSE_EN
    step("b_hold_a", 6);
    check("b_hold_running", 32'(running), 1);
    check("b_hold_dir_a", 32'(dir_up), 1);
    step("b_hold_b", 6);
    check("b_hold_dir_b", 32'(dir_up), 1);
    step("b_hold_c", 6);
    check("b_rev_dir", 32'(dir_up), 0);
    step("b_d5", 5);
    step("b_d4", 4);
    step("b_d3", 3);
    step("b_d2", 2);
    step("b_lo_hold_a", 2);
    step("b_lo_hold_b", 2);
    step("b_lo_hold_c", 2);
    check("b_fwd_dir", 32'(dir_up), 1);
    step("b_u3", 3);
`else
    step("b_idle_hold", 6);
    check("b_idle_running", 32'(running), 0);
    check("b_idle_dir", 32'(dir_up), 1);
`endif

    // Asynchronous reset mid-run at count 5.
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    press_run();
    step("c_c2", 2);
    step("c_c3", 3);
    step("c_c4", 4);
    step("c_c5", 5);
    rst = 1'b0;
    #1;
    check("c_rst_count",   32'(count),   0);
    check("c_rst_dir_up",  32'(dir_up),  1);
    check("c_rst_running", 32'(running), 0);
    check("c_rst_tick",    32'(tick),    0);
    @(negedge clk);
    rst = 1'b1;
    lo_lim = 4'd0;
    hi_lim = 4'd9;
    @(negedge clk);

    // Speed change mid-run, then pause/resume in slow mode.
    press_run();
    step("d_c1", 1);
    speed_sel = 1'b0;
    n = 0;
    while (tick !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    // Edge sampling the change, plus ten clocks to the tick.
    check("d_speed_latency", n, 11);
    @(negedge clk);
    check("d_c2", 32'(count), 2);
    tick_wait("d_period", n);
    check("d_slow_period", n, 9);
    @(negedge clk);
    check("d_c3", 32'(count), 3);
    press_run();
    check("d_pause_running", 32'(running), 0);
    check("d_pause_count", 32'(count), 3);
    repeat (25) @(negedge clk);
    check("d_frozen", 32'(count), 3);
    press_run();
    step("d_resume4", 4);

    // Run press coincident with a tick, and direction flip while paused.
    speed_sel = 1'b1;
    step("e_c5", 5);
    @(negedge clk);
    check("e_tick_align", 32'(tick), 1);
    btn_run = 1'b1;
    repeat (3) @(negedge clk);
    btn_run = 1'b0;
    check("e_pause_running", 32'(running), 0);
    check("e_coincide_count", 32'(count), 6);
    repeat (4) @(negedge clk);
    press_dir();
    check("e_dir_flip", 32'(dir_up), 0);
    check("e_dir_running", 32'(running), 0);
    check("e_dir_count", 32'(count), 6);
    repeat (4) @(negedge clk);
    tick_wait("e_align2", n);
    btn_run = 1'b1;
    repeat (3) @(negedge clk);
    btn_run = 1'b0;
    check("e_resume_running", 32'(running), 1);
    check("e_resume_count", 32'(count), 6);
    step("e_down5", 5);

    // Inverted limits force PAUSE and freeze the count.
    lo_lim = 4'd7;
    hi_lim = 4'd3;
    @(negedge clk);
    check("f_cfg_err", 32'(cfg_err), 1);
    check("f_forced_pause", 32'(running), 0);
    repeat (6) @(negedge clk);
    check("f_frozen", 32'(count), 5);
    lo_lim = 4'd0;
    @(negedge clk);
    check("f_cfg_clear", 32'(cfg_err), 0);
    check("f_still_paused", 32'(running), 0);
    press_run();
    step("f_load_hi", 3);
    step("f_down2", 2);
    check("f_at_limit", 32'(at_limit), 0);

    // lo == hi: load the single value, then the limit action fires.
    lo_lim = 4'd3;
    hi_lim = 4'd3;
    step("g_load", 3);
    check("g_cfg_ok", 32'(cfg_err), 0);
    check("g_at_limit", 32'(at_limit), 1);
    step("g_limit", 3);
`ifdef COUNT_SEQ_AUTO_REVERSE_EN
    check("g_running", 32'(running), 1);
`else
    check("g_running", 32'(running), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
